// File: rtl/tristate_bus_arbiter_if.sv
// Bus-ownership handshake between N tristate requesters and the round-robin arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface tristate_bus_arbiter_if #(
   parameter int N = 4
);
   localparam int OW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  req;
   logic [N-1:0]  en;
   logic          busy;
   logic [OW-1:0] owner;

   modport master (output req, input en, input busy, input owner);
   modport slave  (input req, output en, output busy, output owner);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter generating registered one-hot tristate enables for a shared bus.
// Define TRISTATE_ARB_TURNAROUND_EN to insert one dead bus cycle between owners.
module tristate_bus_arbiter #(
   parameter int N        = 4,
   parameter int MAXBURST = 4
) (
   input logic                   clk,
   input logic                   reset,
   tristate_bus_arbiter_if.slave bus
);
   localparam int OW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(MAXBURST + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAXBURST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  en_q, en_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  others;
   logic [N-1:0]  cand;
   logic [OW-1:0] pick;
   logic          release_own;

   // First set bit searching from 'from'+1 upward with wrap-around.
   function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] from);
      logic [OW-1:0] p;
      int            idx;
      p = from;
      for (int i = N; i >= 1; i--) begin
         idx = (int'(from) + i) % N;
         if (r[idx]) p = OW'(idx);
      end
      return p;
   endfunction

   always_comb begin
      others          = bus.req;
      others[owner_q] = 1'b0;
      release_own     = !bus.req[owner_q] || ((cnt_q == CNT_MAX) && (others != '0));
      cand            = (state_q == OWN) ? others : bus.req;
      pick            = rr_pick(cand, last_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         en_q    <= '0;
         owner_q <= '0;
         last_q  <= OW'(N - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = OWN;
               owner_d = pick;
               last_d  = pick;
               cnt_d   = CW'(1);
            end
         end
         OWN: begin
            if (release_own) begin
`ifdef TRISTATE_ARB_TURNAROUND_EN
               state_d = TURN;
`else
               // Direct handoff: the new owner is chosen among the others only.
               if (|others) begin
                  state_d = OWN;
                  owner_d = pick;
                  last_d  = pick;
                  cnt_d   = CW'(1);
               end else begin
                  state_d = IDLE;
               end
`endif
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef TRISTATE_ARB_TURNAROUND_EN
         TURN: begin
            // last_q still holds the previous owner, so it is searched last.
            if (|bus.req) begin
               state_d = OWN;
               owner_d = pick;
               last_d  = pick;
               cnt_d   = CW'(1);
            end else begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Enables are decoded from the next state and registered, so req never reaches en combinationally.
   always_comb begin
      en_d = '0;
      if (state_d == OWN) en_d[owner_d] = 1'b1;
   end

   assign bus.en    = en_q;
   assign bus.busy  = |en_q;
   assign bus.owner = owner_q;

endmodule
